// File: rtl/csr_diff_queue_pkg.sv
// Shared types and CSR id constants for the difftest CSR-update queue.
package csr_diff_pkg;

  localparam int CSR_ID_W = 12;
  localparam int CSR_XLEN = 64;

  typedef struct packed {
    logic [CSR_ID_W-1:0] id;
    logic [CSR_XLEN-1:0] value;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EPC,
    ST_CAUSE,
    ST_TVAL,
    ST_STATUS
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;

  // sstatus is reported through the mstatus view, so STATUS is mode-independent.
  function automatic logic [11:0] burst_id(state_t st, logic to_s);
    logic [11:0] id;
    case (st)
      ST_EPC:   id = to_s ? CSR_SEPC   : CSR_MEPC;
      ST_CAUSE: id = to_s ? CSR_SCAUSE : CSR_MCAUSE;
      ST_TVAL:  id = to_s ? CSR_STVAL  : CSR_MTVAL;
      default:  id = CSR_MSTATUS;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/csr_diff_queue_fifo.sv
// Circular-buffer FIFO for CSR diff entries; the tail rewrite port exists
// only when CSR_DIFF_COALESCE_EN is defined.
module csr_diff_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 76
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enq,
  input  logic [W-1:0]             enq_data,
  input  logic                     deq,
`ifdef CSR_DIFF_COALESCE_EN
  input  logic                     tail_we,
  input  logic [W-1:0]             tail_data,
  output logic [W-1:0]             tail,
`endif
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] tail_ptr;
  logic          do_enq;
  logic          do_deq;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_enq   = enq && !full;
  assign do_deq   = deq && !empty;
  assign tail_ptr = wr_ptr - 1'b1;
  assign head     = mem[rd_ptr];
`ifdef CSR_DIFF_COALESCE_EN
  assign tail     = mem[tail_ptr];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_enq) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
`ifdef CSR_DIFF_COALESCE_EN
      if (tail_we) mem[tail_ptr] <= tail_data;
`endif
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/csr_diff_queue.sv
// Orders commit CSR writes and trap bursts into one {id, value} stream for difftest.
// Define CSR_DIFF_COALESCE_EN to fold repeated writes to the tail CSR into one entry.
module csr_diff_queue
  import csr_diff_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 12,
  parameter int XLEN  = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ID_W-1:0]      in_id,
  input  logic [XLEN-1:0]      in_data,
  input  logic                 trap_valid,
  output logic                 trap_ready,
  input  logic                 trap_to_s,
  input  logic [XLEN-1:0]      trap_epc,
  input  logic [XLEN-1:0]      trap_cause,
  input  logic [XLEN-1:0]      trap_tval,
  input  logic [XLEN-1:0]      trap_status,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_W+XLEN-1:0] out_bits,
  input  logic [1:0]           priv_in,
  output logic [1:0]           priv_out
);

  localparam int W  = ID_W + XLEN;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef CSR_DIFF_COALESCE_EN
  // Extra MSB marks trap-burst entries so they are never coalesce targets.
  localparam int FW = W + 1;
`else
  localparam int FW = W;
`endif

  state_t          state;
  logic            to_s_q;
  logic [XLEN-1:0] epc_q, cause_q, tval_q, status_q;

  logic [FW-1:0]   head;
  logic [FW-1:0]   enq_data;
  logic [CW-1:0]   count;
  logic            full, empty;
  logic            enq, deq, in_fire, trap_fire, burst_enq;
  logic [ID_W-1:0] b_id;
  logic [XLEN-1:0] b_val;

  assign out_valid  = !empty;
  assign out_bits   = head[W-1:0];
  assign deq        = out_valid && out_ready;
  assign trap_ready = !reset && (state == ST_IDLE);
  assign in_fire    = in_valid && in_ready;
  assign trap_fire  = trap_valid && trap_ready;
  assign burst_enq  = (state != ST_IDLE) && !full;
  assign b_id       = ID_W'(burst_id(state, to_s_q));

  always_comb begin
    b_val = status_q;
    case (state)
      ST_EPC:   b_val = epc_q;
      ST_CAUSE: b_val = cause_q;
      ST_TVAL:  b_val = tval_q;
      default:  b_val = status_q;
    endcase
  end

`ifdef CSR_DIFF_COALESCE_EN
  logic [FW-1:0] tail;
  logic          hit;
  logic          tail_we;

  // With a lone entry being dequeued this cycle the tail is leaving, so no fold.
  assign hit = in_valid && (state == ST_IDLE) && !tail[W] &&
               (tail[W-1:XLEN] == in_id) &&
               ((count >= CW'(2)) || ((count == CW'(1)) && !deq));
  assign in_ready = !reset && (state == ST_IDLE) && (!full || hit);
  assign tail_we  = in_fire && hit;
  assign enq      = (in_fire && !hit) || burst_enq;
  assign enq_data = burst_enq ? {1'b1, b_id, b_val} : {1'b0, in_id, in_data};
`else
  assign in_ready = !reset && (state == ST_IDLE) && !full;
  assign enq      = in_fire || burst_enq;
  assign enq_data = burst_enq ? {b_id, b_val} : {in_id, in_data};
`endif

  csr_diff_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq       (enq),
    .enq_data  (enq_data),
    .deq       (deq),
`ifdef CSR_DIFF_COALESCE_EN
    .tail_we   (tail_we),
    .tail_data ({1'b0, in_id, in_data}),
    .tail      (tail),
`endif
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // A write firing alongside the trap is enqueued now; the burst starts next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      to_s_q   <= 1'b0;
      epc_q    <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      status_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (trap_fire) begin
          to_s_q   <= trap_to_s;
          epc_q    <= trap_epc;
          cause_q  <= trap_cause;
          tval_q   <= trap_tval;
          status_q <= trap_status;
          state    <= ST_EPC;
        end
        ST_EPC:    if (!full) state <= ST_CAUSE;
        ST_CAUSE:  if (!full) state <= ST_TVAL;
        ST_TVAL:   if (!full) state <= ST_STATUS;
        ST_STATUS: if (!full) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) priv_out <= 2'b11;
    else       priv_out <= priv_in;
  end

endmodule

// File: tb/tb_csr_diff_queue.sv
// Directed bench for csr_diff_queue with an in-order scoreboard on the output stream.
module tb_csr_diff_queue;
  import csr_diff_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [11:0] in_id;
  logic [63:0] in_data;
  logic        trap_valid, trap_ready, trap_to_s;
  logic [63:0] trap_epc, trap_cause, trap_tval, trap_status;
  logic        out_valid, out_ready;
  logic [75:0] out_bits;
  logic [1:0]  priv_in, priv_out;

  int vectors     = 0;
  int miscompares = 0;
  int deq_seen    = 0;
  logic [75:0] sb[$];

  always #5 clock = ~clock;

  csr_diff_queue #(.DEPTH(4), .ID_W(12), .XLEN(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_id       (in_id),
    .in_data     (in_data),
    .trap_valid  (trap_valid),
    .trap_ready  (trap_ready),
    .trap_to_s   (trap_to_s),
    .trap_epc    (trap_epc),
    .trap_cause  (trap_cause),
    .trap_tval   (trap_tval),
    .trap_status (trap_status),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bits    (out_bits),
    .priv_in     (priv_in),
    .priv_out    (priv_out)
  );

  function automatic logic [75:0] ent(input logic [11:0] id, input logic [63:0] val);
    entry_t e;
    e.id    = id;
    e.value = val;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clock);
    if (!reset && out_valid && out_ready) begin
      deq_seen++;
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL sb_unexpected observed=%h expected=none", out_bits);
      end
      if (sb.size() != 0) chk("sb_order", out_bits, sb.pop_front());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_trap(input logic to_s, input logic [63:0] epc, input logic [63:0] cause,
                          input logic [63:0] tval, input logic [63:0] status);
    out_ready   = 1'b1;
    trap_valid  = 1'b1;
    trap_to_s   = to_s;
    trap_epc    = epc;
    trap_cause  = cause;
    trap_tval   = tval;
    trap_status = status;
    chk("trap_rdy_idle", trap_ready, 1'b1);
    sb.push_back(ent(to_s ? 12'h141 : 12'h341, epc));
    sb.push_back(ent(to_s ? 12'h142 : 12'h342, cause));
    sb.push_back(ent(to_s ? 12'h143 : 12'h343, tval));
    sb.push_back(ent(12'h300, status));
    tick();
    trap_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("trap_rdy_low", trap_ready, 1'b0);
      chk("trap_stream_vld", out_valid, (i != 0));
      tick();
    end
    chk("trap_rdy_back", trap_ready, 1'b1);
    chk("trap_last_vld", out_valid, 1'b1);
    tick();
    chk("trap_drained", out_valid, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b1;
    in_id       = '0;
    in_data     = '0;
    trap_valid  = 1'b1;
    trap_to_s   = 1'b0;
    trap_epc    = '0;
    trap_cause  = '0;
    trap_tval   = '0;
    trap_status = '0;
    out_ready   = 1'b1;
    priv_in     = 2'b00;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bits", out_bits, 76'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_trap_ready", trap_ready, 1'b0);
    chk("rst_priv", priv_out, 2'b11);
    in_valid   = 1'b0;
    trap_valid = 1'b0;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    priv_in = 2'b01;
    tick();
    chk("priv_lat1", priv_out, 2'b01);
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_trap_ready", trap_ready, 1'b1);
    priv_in = 2'b11;

    // Single write, one-cycle visibility.
    in_valid = 1'b1;
    in_id    = 12'h305;
    in_data  = 64'h0000_0000_8000_0000;
    chk("wr_in_ready", in_ready, 1'b1);
    sb.push_back(ent(12'h305, 64'h0000_0000_8000_0000));
    tick();
    in_valid = 1'b0;
    chk("wr_lat_vld", out_valid, 1'b1);
    chk("wr_lat_bits", out_bits, ent(12'h305, 64'h0000_0000_8000_0000));
    chk("priv_lat2", priv_out, 2'b11);
    tick();
    chk("wr_one_cycle", out_valid, 1'b0);

    run_trap(1'b0, 64'h8000_1000, 64'd2, 64'hdead, 64'h1800);
    run_trap(1'b1, 64'h8000_1000, 64'd2, 64'hdead, 64'h1800);

    // Fill past depth with consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_id    = 12'h7A0 + 12'(i);
      in_data  = {32'hA5A5_0F0F, 32'(i)};
      chk("fill_rdy", in_ready, (i < 4));
      if (i < 4) sb.push_back(ent(12'h7A0 + 12'(i), {32'hA5A5_0F0F, 32'(i)}));
      tick();
    end
    in_id     = 12'h7B0;
    out_ready = 1'b1;
    chk("full_deq_rdy", in_ready, 1'b0);
    chk("full_vld", out_valid, 1'b1);
    in_valid = 1'b0;
    repeat (4) tick();
    chk("fill_drained", out_valid, 1'b0);
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1;
      in_id    = 12'h7C0 + 12'(j);
      in_data  = {32'h0, 32'(j + 100)};
      sb.push_back(ent(12'h7C0 + 12'(j), {32'h0, 32'(j + 100)}));
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    chk("wrap_drained", out_valid, 1'b0);

    // Write and trap in the same cycle: write goes first.
    in_valid    = 1'b1;
    in_id       = 12'h180;
    in_data     = 64'h8000_0000_0008_0000;
    trap_valid  = 1'b1;
    trap_to_s   = 1'b0;
    trap_epc    = 64'h1111;
    trap_cause  = 64'h2222;
    trap_tval   = 64'h3333;
    trap_status = 64'h4444;
    chk("both_in_ready", in_ready, 1'b1);
    chk("both_trap_ready", trap_ready, 1'b1);
    sb.push_back(ent(12'h180, 64'h8000_0000_0008_0000));
    sb.push_back(ent(12'h341, 64'h1111));
    sb.push_back(ent(12'h342, 64'h2222));
    sb.push_back(ent(12'h343, 64'h3333));
    sb.push_back(ent(12'h300, 64'h4444));
    tick();
    in_valid   = 1'b0;
    trap_valid = 1'b0;
    repeat (6) tick();
    chk("both_drained", out_valid, 1'b0);

    // Reset lands mid-burst; nothing may survive it.
    out_ready  = 1'b0;
    trap_valid = 1'b1;
    trap_to_s  = 1'b1;
    tick();
    trap_valid = 1'b0;
    repeat (2) tick();
    chk("mid_burst_vld", out_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_async_vld", out_valid, 1'b0);
    chk("rst_async_trdy", trap_ready, 1'b0);
    repeat (2) tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("post_rst_empty", out_valid, 1'b0);
    chk("post_rst_trdy", trap_ready, 1'b1);

    // Repeated writes to one CSR with consumer stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_id     = 12'h340; in_data = 64'd1; chk("coal_rdy0", in_ready, 1'b1); tick();
    in_id     = 12'h340; in_data = 64'd2; chk("coal_rdy1", in_ready, 1'b1); tick();
    in_id     = 12'h341; in_data = 64'd3; chk("coal_rdy2", in_ready, 1'b1); tick();
    in_valid  = 1'b0;
`ifdef CSR_DIFF_COALESCE_EN
    sb.push_back(ent(12'h340, 64'd2));
    sb.push_back(ent(12'h341, 64'd3));
    chk("coal_head", out_bits, ent(12'h340, 64'd2));
`else
    sb.push_back(ent(12'h340, 64'd1));
    sb.push_back(ent(12'h340, 64'd2));
    sb.push_back(ent(12'h341, 64'd3));
    chk("coal_head", out_bits, ent(12'h340, 64'd1));
`endif
    deq_seen  = 0;
    out_ready = 1'b1;
    repeat (5) tick();
`ifdef CSR_DIFF_COALESCE_EN
    chk("coal_count", 76'(deq_seen), 76'd2);
`else
    chk("coal_count", 76'(deq_seen), 76'd3);
`endif
    chk("sb_empty", 76'(sb.size()), 76'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csr_diff_queue.md
Name: csr_diff_queue

Overview:
- Upstream feeder of the difftest CSR-update interface.
- Captures CSR write events from commit (single writes plus trap bursts) and buffers them in order.
- Emits them one per cycle as 76-bit tagged entries: {id[11:0], value[63:0]}.
- Also registers the privilege level for the difftest priv update.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- ID_W, 12, CSR address width.
- XLEN, 64, CSR value width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  single CSR write from commit.
- in_ready  out  1  write accepted when in_valid&&in_ready.
- in_id  in  ID_W  CSR address.
- in_data  in  XLEN  value written.
- trap_valid  in  1  trap taken at commit.
- trap_ready  out  1  trap accepted when trap_valid&&trap_ready.
- trap_to_s  in  1  1 = delegated to S-mode, 0 = M-mode.
- trap_epc / trap_cause / trap_tval / trap_status  in  XLEN each  trap payload.
- out_valid  out  1  entry available.
- out_ready  in  1  consumer takes entry.
- out_bits  out  ID_W+XLEN  {id, value} of FIFO head.
- priv_in  in  2  current privilege.
- priv_out  out  2  registered privilege.

Behaviour:
- Reset (async, reset=1): FIFO empty, FSM=IDLE, out_valid=0, out_bits=0, in_ready=0 while reset is asserted, trap_ready=0, priv_out=2'b11.
  - Release mid-burst discards all pending entries and any latched trap.
- FIFO: circular buffer with log2(DEPTH)-bit pointers and a (log2(DEPTH)+1)-bit count.
  - out_valid = count!=0; out_bits = head entry.
  - Dequeue on out_valid&&out_ready. Pointers wrap modulo DEPTH.
  - One enqueue and one dequeue may occur in the same cycle; count is unchanged.
  - A full FIFO with a simultaneous dequeue still reports in_ready=0. There is no same-cycle bypass.
- Enqueue: at most one enqueue per cycle. Enqueue latency is 1 cycle: an entry accepted in cycle N is visible on out_bits in cycle N+1.
- in_ready = (state==IDLE) && !full.
- trap_ready = (state==IDLE).
  - If in and trap fire in the same cycle, the single write is enqueued that cycle. The trap payload is latched, and the FSM goes to EPC next cycle. The single write is therefore ordered before the trap.
- Trap FSM: IDLE -> EPC -> CAUSE -> TVAL -> STATUS -> IDLE.
  - Each non-IDLE state enqueues one entry when !full; otherwise it holds the state.
  - Ids when trap_to_s=0: 0x341, 0x342, 0x343, 0x300.
  - Ids when trap_to_s=1: 0x141, 0x142, 0x143, 0x300. sstatus is reported as the mstatus view.
  - The latched payload is stable until STATUS enqueues.
- priv_out <= priv_in every cycle (1-cycle latency).
- No arithmetic on data. Ids and values pass through unmodified; ids are zero-extended by the consumer.

Optional Feature:
- Macro: CSR_DIFF_COALESCE_EN.
- With the macro: an in write whose in_id equals the tail entry id overwrites the tail value instead of enqueueing.
  - Condition: count>=2, or count==1 with no same-cycle dequeue.
  - in_ready becomes (state==IDLE) && (!full || hit).
  - Trap-burst entries never coalesce, and never serve as the tail target of a coalesce.
- Without the macro: every accepted write occupies a new entry.

Decomposition:
- Shared package csr_diff_pkg:
  - Entry typedef {id, value}.
  - FSM state enum.
  - CSR id constants (MSTATUS 0x300, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343, SEPC 0x141, SCAUSE 0x142, STVAL 0x143).
- One sub-module: csr_diff_fifo (storage, pointers, count, full/empty, tail-write port for coalesce).
- The FSM and arbitration stay in the top.

Test Plan:
- Reset, then in write id 0x305 data 0x8000_0000 with out_ready=1 -> out_bits={0x305, 0x8000_0000} in the next cycle, out_valid for 1 cycle, priv_out=3.
- trap_valid, trap_to_s=0, epc=0x80001000, cause=2, tval=0xdead, status=0x1800, out_ready=1 -> 4 consecutive entries 0x341, 0x342, 0x343, 0x300 with those values; trap_ready low for 4 cycles.
- Same trap with trap_to_s=1 -> ids 0x141, 0x142, 0x143, 0x300.
- out_ready=0 with 6 writes offered at DEPTH=4 -> 4 accepted, in_ready=0 at count 4; release out_ready -> all 4 drain in order, pointers wrap correctly.
- in and trap in the same cycle -> the single write is emitted first, then the 4-entry burst; assert async reset mid-burst -> out_valid=0 immediately and the FIFO stays empty after release.
- With CSR_DIFF_COALESCE_EN, out_ready=0, writes 0x340 value 1, then 0x340 value 2, then 0x341 value 3 -> count=2, entries {0x340,2} and {0x341,3}. Without the macro, count=3.
